// File: rtl/ram_boot_sequencer_if.sv
// ram_boot_sequencer_if: UART receive handshake plus the CPU-side and RAM-side
// memory buses that the boot sequencer sits between.
//   uart_valid/uart_data/uart_rd   : buart receive handshake
//   cpu_mem_*                      : RAM requests from the rcpu core
//   ram_*                          : ports to ram_memory
// 16-bit buses use [0:15] ordering (bit 0 is the MSB).
// modport master: the sequencer; modport slave: the surrounding system.
interface ram_boot_sequencer_if;
  logic        uart_valid;
  logic [7:0]  uart_data;
  logic        uart_rd;

  logic        cpu_mem_read_enable;
  logic        cpu_mem_write_enable;
  logic [0:15] cpu_mem_read_address;
  logic [0:15] cpu_mem_write_address;
  logic [0:15] cpu_mem_write_data;

  logic        ram_read_enable;
  logic        ram_write_enable;
  logic [0:15] ram_read_addr;
  logic [0:15] ram_write_addr;
  logic [0:15] ram_write_data;

  modport master (
    input  uart_valid, uart_data,
    output uart_rd,
    input  cpu_mem_read_enable, cpu_mem_write_enable,
    input  cpu_mem_read_address, cpu_mem_write_address, cpu_mem_write_data,
    output ram_read_enable, ram_write_enable,
    output ram_read_addr, ram_write_addr, ram_write_data
  );

  modport slave (
    output uart_valid, uart_data,
    input  uart_rd,
    output cpu_mem_read_enable, cpu_mem_write_enable,
    output cpu_mem_read_address, cpu_mem_write_address, cpu_mem_write_data,
    input  ram_read_enable, ram_write_enable,
    input  ram_read_addr, ram_write_addr, ram_write_data
  );
endinterface

// File: rtl/ram_boot_sequencer.sv
// ram_boot_sequencer: waits for PLL lock plus a settle delay, then either
// releases the CPU or first loads a program image received over the UART into
// RAM. Owns the CPU reset (cpu_run) and arbitrates the RAM ports.
//   clk, resetq (async, active-low)
//   pll_lock   : PLL locked
//   boot_req   : asynchronous load request, sampled once in DECIDE
//   bus        : UART handshake, CPU requests, RAM ports (master side)
//   cpu_run    : 1 lets the CPU run
//   loading    : loader owns RAM and a load is in progress
//   load_error : sticky until reset
module ram_boot_sequencer #(
  parameter int unsigned STARTUP_TICKS  = 40,
  parameter int unsigned MEM_WORDS      = 4096,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd4800000
) (
  input  logic                 clk,
  input  logic                 resetq,
  input  logic                 pll_lock,
  input  logic                 boot_req,
  ram_boot_sequencer_if.master bus,
  output logic                 cpu_run,
  output logic                 loading,
  output logic                 load_error
);

  localparam int unsigned TICK_W = $clog2(STARTUP_TICKS + 2);
  localparam int unsigned IDX_W  = 13;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned TO_W   = 24;

  typedef enum logic [3:0] {
    WAIT_LOCK, SETTLE, DECIDE, LEN_HI, LEN_LO, DATA_HI, DATA_LO,
    WRITE, CSUM, RUN, ERROR
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [TICK_W-1:0]  r_tick;
  logic               r_boot_s1;
  logic               r_boot_s2;
  logic [LEN_W-1:0]   r_len;
  logic [IDX_W-1:0]   r_idx;
  logic [7:0]         r_hi;
  logic [7:0]         r_lo;
  logic [7:0]         r_csum;
  logic [TO_W-1:0]    r_idle;
  logic               r_uart_rd;
  logic               r_cpu_run;
  logic               r_loading;
  logic               r_load_error;

  logic               w_rx_state;
  logic               w_take;
  logic               w_timeout;
  logic [LEN_W-1:0]   w_len;
  logic               w_loading_nxt;

  // A byte is taken only when no strobe went out last cycle (buart still shows the old byte)
  assign w_rx_state = (r_state == LEN_HI) || (r_state == LEN_LO) || (r_state == DATA_HI) ||
                      (r_state == DATA_LO) || (r_state == CSUM);
  assign w_take     = w_rx_state && bus.uart_valid && !r_uart_rd;
  assign w_timeout  = w_rx_state && (r_idle == TIMEOUT_CYCLES);
  assign w_len      = {r_len[15:8], bus.uart_data};

  // State register
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) r_state <= WAIT_LOCK;
    else         r_state <= w_state_nxt;
  end

  // Next-state and registered-output decode
  always_comb begin
    w_state_nxt   = r_state;
    w_loading_nxt = 1'b0;
    case (r_state)
      WAIT_LOCK: if (pll_lock) w_state_nxt = SETTLE;
      SETTLE: begin
        if (!pll_lock)                              w_state_nxt = WAIT_LOCK;
        else if (r_tick == TICK_W'(STARTUP_TICKS))  w_state_nxt = DECIDE;
      end
      DECIDE:  w_state_nxt = r_boot_s2 ? LEN_HI : RUN;
      LEN_HI:  if (w_take) w_state_nxt = LEN_LO;
      LEN_LO: begin
        if (w_take) begin
          if (w_len == '0)                          w_state_nxt = CSUM;
          else if (w_len > LEN_W'(MEM_WORDS))       w_state_nxt = ERROR;
          else                                      w_state_nxt = DATA_HI;
        end
      end
      DATA_HI: if (w_take) w_state_nxt = DATA_LO;
      DATA_LO: if (w_take) w_state_nxt = WRITE;
      WRITE:   w_state_nxt = (LEN_W'(r_idx) + LEN_W'(1) == r_len) ? CSUM : DATA_HI;
      CSUM:    if (w_take) w_state_nxt = (bus.uart_data == r_csum) ? RUN : ERROR;
      RUN:     w_state_nxt = RUN;
      ERROR:   w_state_nxt = ERROR;
      default: w_state_nxt = WAIT_LOCK;
    endcase
    if (w_timeout) w_state_nxt = ERROR;

    case (w_state_nxt)
      LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CSUM: w_loading_nxt = 1'b1;
      default:                                       w_loading_nxt = 1'b0;
    endcase
  end

  // Datapath: settle counter, boot_req synchronizer, frame capture, idle timer, outputs
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_tick       <= '0;
      r_boot_s1    <= 1'b0;
      r_boot_s2    <= 1'b0;
      r_len        <= '0;
      r_idx        <= '0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_csum       <= '0;
      r_idle       <= '0;
      r_uart_rd    <= 1'b0;
      r_cpu_run    <= 1'b0;
      r_loading    <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_boot_s1    <= boot_req;
      r_boot_s2    <= r_boot_s1;
      r_uart_rd    <= w_take && !w_timeout;
      r_cpu_run    <= (r_state == RUN);
      r_loading    <= w_loading_nxt;
      r_load_error <= (w_state_nxt == ERROR);

      r_tick <= (r_state == SETTLE) ? r_tick + TICK_W'(1) : '0;

      if (r_state == DECIDE) r_csum <= '0;

      if (w_take) begin
        case (r_state)
          LEN_HI:  r_len[15:8] <= bus.uart_data;
          LEN_LO: begin
            r_len[7:0] <= bus.uart_data;
            r_idx      <= '0;
          end
          DATA_HI: begin
            r_hi   <= bus.uart_data;
            r_csum <= r_csum ^ bus.uart_data;
          end
          DATA_LO: begin
            r_lo   <= bus.uart_data;
            r_csum <= r_csum ^ bus.uart_data;
          end
          default: ;
        endcase
      end

      if (r_state == WRITE) r_idx <= r_idx + IDX_W'(1);

      // WRITE sits inside a frame, so the idle gap keeps counting across it
      if (!w_rx_state && r_state != WRITE) r_idle <= '0;
      else if (w_take)                     r_idle <= '0;
      else if (w_rx_state && !bus.uart_valid) r_idle <= r_idle + TO_W'(1);
    end
  end

  // RAM port mux, combinational on the registered state
  always_comb begin
    bus.ram_read_enable  = 1'b0;
    bus.ram_write_enable = 1'b0;
    bus.ram_read_addr    = '0;
    bus.ram_write_addr   = '0;
    bus.ram_write_data   = '0;
    if (r_state == RUN) begin
      bus.ram_read_enable  = bus.cpu_mem_read_enable;
      bus.ram_write_enable = bus.cpu_mem_write_enable;
      bus.ram_read_addr    = bus.cpu_mem_read_address;
      bus.ram_write_addr   = bus.cpu_mem_write_address;
      bus.ram_write_data   = bus.cpu_mem_write_data;
    end else if (r_state == WRITE) begin
      bus.ram_write_enable = 1'b1;
      bus.ram_write_addr   = LEN_W'(r_idx);
      bus.ram_write_data   = {r_hi, r_lo};
    end
  end

  assign bus.uart_rd = r_uart_rd;
  assign cpu_run     = r_cpu_run;
  assign loading     = r_loading;
  assign load_error  = r_load_error;

endmodule

// File: tb/tb_ram_boot_sequencer.sv
// tb_ram_boot_sequencer: directed bench for ram_boot_sequencer. Expected RAM
// writes are queued as stimulus is issued; a negedge monitor pops and compares
// every write the DUT presents. Status outputs are checked directly.
module tb_ram_boot_sequencer;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic clk;
  logic resetq;
  logic pll_lock;
  logic boot_req;
  logic cpu_run;
  logic loading;
  logic load_error;

  int checks;
  int failures;
  wr_t exp_q[$];

  ram_boot_sequencer_if bus();

  ram_boot_sequencer #(
    .STARTUP_TICKS (40),
    .MEM_WORDS     (4096),
    .TIMEOUT_CYCLES(24'd100)
  ) dut (
    .clk       (clk),
    .resetq    (resetq),
    .pll_lock  (pll_lock),
    .boot_req  (boot_req),
    .bus       (bus.master),
    .cpu_run   (cpu_run),
    .loading   (loading),
    .load_error(load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every RAM write must match the head of the expectation queue
  always @(negedge clk) begin
    if (bus.ram_write_enable === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL ram_write_unexpected: got addr %0h data %0h expected no write",
                 bus.ram_write_addr, bus.ram_write_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.ram_write_addr !== e.addr || bus.ram_write_data !== e.data) begin
          failures++;
          $display("FAIL ram_write: got addr %0h data %0h expected addr %0h data %0h",
                   bus.ram_write_addr, bus.ram_write_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [15:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check_queue_empty(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // buart model: present a byte, wait for the strobe, drop valid on the next edge
  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    bus.uart_data  = b;
    bus.uart_valid = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      tick(1);
      if (bus.uart_rd === 1'b1) got = 1'b1;
    end
    check("uart_rd_strobe", 32'(got), 32'd1);
    tick(1);
    bus.uart_valid = 1'b0;
    tick(2);
  endtask

  task automatic do_reset();
    resetq                    = 1'b0;
    pll_lock                  = 1'b0;
    boot_req                  = 1'b0;
    bus.uart_valid            = 1'b0;
    bus.uart_data             = 8'h00;
    bus.cpu_mem_read_enable   = 1'b0;
    bus.cpu_mem_write_enable  = 1'b0;
    bus.cpu_mem_read_address  = 16'h0000;
    bus.cpu_mem_write_address = 16'h0000;
    bus.cpu_mem_write_data    = 16'h0000;
    tick(3);
  endtask

  task automatic send_frame_head();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hAB);
    send_byte(8'hCD);
  endtask

  initial begin
    logic [7:0] frame_bytes [7];
    bit seen;
    checks   = 0;
    failures = 0;

    // Reset values
    do_reset();
    check("rst_cpu_run",    32'(cpu_run),              32'd0);
    check("rst_loading",    32'(loading),              32'd0);
    check("rst_load_error", 32'(load_error),           32'd0);
    check("rst_uart_rd",    32'(bus.uart_rd),          32'd0);
    check("rst_ram_we",     32'(bus.ram_write_enable), 32'd0);
    check("rst_ram_re",     32'(bus.ram_read_enable),  32'd0);
    check("rst_ram_waddr",  32'(bus.ram_write_addr),   32'd0);

    // No boot: release at lock + 43, CPU read passes through the same edge RUN is entered
    resetq   = 1'b1;
    pll_lock = 1'b1;
    bus.cpu_mem_read_enable  = 1'b1;
    bus.cpu_mem_read_address = 16'h0007;
    tick(42);
    check("noboot_decide_re_blocked", 32'(bus.ram_read_enable), 32'd0);
    tick(1);
    check("noboot_run_re",    32'(bus.ram_read_enable), 32'd1);
    check("noboot_run_raddr", 32'(bus.ram_read_addr),   32'h0007);
    check("noboot_cpu_run_late", 32'(cpu_run),           32'd0);
    tick(1);
    check("noboot_cpu_run",   32'(cpu_run),             32'd1);
    bus.cpu_mem_write_enable  = 1'b1;
    bus.cpu_mem_write_address = 16'h0055;
    bus.cpu_mem_write_data    = 16'hBEEF;
    expect_write(16'h0055, 16'hBEEF);
    tick(1);
    bus.cpu_mem_write_enable = 1'b0;
    tick(2);
    check_queue_empty("noboot_writes_done");

    // Lock glitch at settle count 20 restarts the settle delay
    do_reset();
    resetq   = 1'b1;
    pll_lock = 1'b1;
    tick(21);
    pll_lock = 1'b0;
    tick(3);
    check("glitch_cpu_run_low", 32'(cpu_run), 32'd0);
    pll_lock = 1'b1;
    tick(43);
    check("glitch_not_yet", 32'(cpu_run), 32'd0);
    tick(1);
    check("glitch_release", 32'(cpu_run), 32'd1);

    // Good load: two words, checksum 0x40
    do_reset();
    boot_req = 1'b1;
    resetq   = 1'b1;
    pll_lock = 1'b1;
    expect_write(16'h0000, 16'h1234);
    expect_write(16'h0001, 16'hABCD);
    frame_bytes = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_byte(frame_bytes[0]);
    check("load_loading", 32'(loading), 32'd1);
    for (int i = 1; i < 7; i++) send_byte(frame_bytes[i]);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (cpu_run === 1'b1) seen = 1'b1;
      else tick(1);
    end
    check("load_cpu_run",    32'(seen),       32'd1);
    check("load_no_error",   32'(load_error), 32'd0);
    check("load_loading_off", 32'(loading),   32'd0);
    check_queue_empty("load_writes_done");

    // Bad checksum: words still land, then ERROR holds the CPU in reset
    do_reset();
    boot_req = 1'b1;
    resetq   = 1'b1;
    pll_lock = 1'b1;
    expect_write(16'h0000, 16'h1234);
    expect_write(16'h0001, 16'hABCD);
    send_frame_head();
    send_byte(8'h41);
    check("badcsum_error",   32'(load_error), 32'd1);
    check("badcsum_cpu_run", 32'(cpu_run),    32'd0);
    tick(10000);
    check("badcsum_cpu_run_10k", 32'(cpu_run),    32'd0);
    check("badcsum_error_sticky", 32'(load_error), 32'd1);
    check_queue_empty("badcsum_writes_done");

    // Oversize length 0x1001: ERROR after second byte, CPU requests ignored, no write
    do_reset();
    boot_req = 1'b1;
    resetq   = 1'b1;
    pll_lock = 1'b1;
    bus.cpu_mem_read_enable   = 1'b1;
    bus.cpu_mem_write_enable  = 1'b1;
    bus.cpu_mem_write_address = 16'h0100;
    bus.cpu_mem_write_data    = 16'h5A5A;
    send_byte(8'h10);
    check("oversize_not_yet", 32'(load_error), 32'd0);
    send_byte(8'h01);
    check("oversize_error",  32'(load_error),          32'd1);
    check("oversize_re_off", 32'(bus.ram_read_enable), 32'd0);
    tick(5);
    check_queue_empty("oversize_no_write");

    // Timeout: stall after three bytes
    do_reset();
    boot_req = 1'b1;
    resetq   = 1'b1;
    pll_lock = 1'b1;
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    tick(50);
    check("timeout_early", 32'(load_error), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 120 && !seen; i++) begin
      if (load_error === 1'b1) seen = 1'b1;
      else tick(1);
    end
    check("timeout_error", 32'(seen), 32'd1);
    check("timeout_cpu_run", 32'(cpu_run), 32'd0);

    // Asynchronous reset mid-frame after the first word write
    do_reset();
    boot_req = 1'b1;
    resetq   = 1'b1;
    pll_lock = 1'b1;
    expect_write(16'h0000, 16'h1234);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hAB);
    check("midrst_loading_before", 32'(loading), 32'd1);
    #2;
    resetq = 1'b0;
    #1;
    check("midrst_loading",   32'(loading),              32'd0);
    check("midrst_cpu_run",   32'(cpu_run),              32'd0);
    check("midrst_error",     32'(load_error),           32'd0);
    check("midrst_uart_rd",   32'(bus.uart_rd),          32'd0);
    check("midrst_ram_we",    32'(bus.ram_write_enable), 32'd0);
    tick(2);
    check_queue_empty("midrst_writes_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
